// File: rtl/vpu_pkg.sv
// Shared types and default sizing for the VPU bias controller.
// No logic; no latency; no backpressure.
// The enum order is the FSM encoding used by vpu_bias_ctrl.
package vpu_pkg;

    localparam int PSUM_WIDTH_DEF = 32;
    localparam int NUM_LANES_DEF  = 4;
    localparam int ROW_CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef logic signed [PSUM_WIDTH_DEF-1:0] psum_t;

endpackage

// File: rtl/vpu_bias_bank.sv
// Lane-indexed bias register bank with one write port and a flat read vector.
// Latency: a write is visible on rd_flat one cycle after wr_en.
// Backpressure: none; the caller gates wr_en.
module vpu_bias_bank #(
    parameter int PSUM_WIDTH = 32,
    parameter int NUM_LANES  = 4,
    parameter int IDX_W      = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [IDX_W-1:0]                wr_idx,
    input  logic [PSUM_WIDTH-1:0]           wr_data,
    output logic [NUM_LANES*PSUM_WIDTH-1:0] rd_flat
);

    logic [PSUM_WIDTH-1:0] bank [NUM_LANES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) bank[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wr_en && wr_idx == IDX_W'(i)) bank[i] <= wr_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_rd
        assign rd_flat[g*PSUM_WIDTH +: PSUM_WIDTH] = bank[g];
    end

endmodule

// File: rtl/vpu_bias_ctrl.sv
// Per-lane bias sequencer: loads the bias bank, drives lane enables, counts rows, pulses done.
// Latency: bias_enable/done registered; row to biased output is 0 cycles in the lanes.
// Backpressure: bias_wr_ready only in LOAD (or !shadow_full with VPU_BIAS_CTRL_DBUF_EN).
module vpu_bias_ctrl
    import vpu_pkg::*;
#(
    parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int NUM_LANES  = NUM_LANES_DEF,
    parameter int ROW_CNT_W  = ROW_CNT_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_start,
    input  logic                            cfg_bias_en,
    input  logic [ROW_CNT_W-1:0]            cfg_num_rows,
    input  logic                            bias_wr_valid,
    output logic                            bias_wr_ready,
    input  logic [PSUM_WIDTH-1:0]           bias_wr_data,
    input  logic                            row_valid,
    output logic                            bias_enable,
    output logic [NUM_LANES*PSUM_WIDTH-1:0] bias_value,
    output logic                            busy,
    output logic                            done,
    output logic                            row_err
);

    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

    state_t               state;
    logic [ROW_CNT_W-1:0] num_rows;
    logic [ROW_CNT_W-1:0] row_cnt;
    logic                 bias_en_q;
    logic [IDX_W-1:0]     lane_idx;
    logic                 wr_fire;
    logic                 row_last;
    logic                 skip_load;

    assign busy     = (state != IDLE);
    assign wr_fire  = bias_wr_valid && bias_wr_ready;
    assign row_last = (row_cnt == num_rows - ROW_CNT_W'(1));

`ifdef VPU_BIAS_CTRL_DBUF_EN
    logic                            act_sel;
    logic                            shadow_full;
    logic [IDX_W-1:0]                shadow_idx;
    logic                            load_fire;
    logic                            shadow_fire;
    logic                            swap;
    logic [NUM_LANES*PSUM_WIDTH-1:0] rd0;
    logic [NUM_LANES*PSUM_WIDTH-1:0] rd1;

    assign bias_wr_ready = (state == LOAD) || !shadow_full;
    assign load_fire     = wr_fire && (state == LOAD);
    assign shadow_fire   = wr_fire && (state != LOAD);
    assign swap          = (state == IDLE) && cfg_start && cfg_bias_en && shadow_full
                           && (cfg_num_rows != '0);
    assign skip_load     = shadow_full;
    assign bias_value    = act_sel ? rd1 : rd0;

    vpu_bias_bank #(.PSUM_WIDTH(PSUM_WIDTH), .NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   ((load_fire && !act_sel) || (shadow_fire && act_sel)),
        .wr_idx  (load_fire ? lane_idx : shadow_idx),
        .wr_data (bias_wr_data),
        .rd_flat (rd0)
    );

    vpu_bias_bank #(.PSUM_WIDTH(PSUM_WIDTH), .NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   ((load_fire && act_sel) || (shadow_fire && !act_sel)),
        .wr_idx  (load_fire ? lane_idx : shadow_idx),
        .wr_data (bias_wr_data),
        .rd_flat (rd1)
    );

    // Shadow fill runs independently of the job FSM; swap and shadow_fire never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_sel     <= 1'b0;
            shadow_full <= 1'b0;
            shadow_idx  <= '0;
        end else if (swap) begin
            act_sel     <= !act_sel;
            shadow_full <= 1'b0;
        end else if (shadow_fire) begin
            if (shadow_idx == LAST_IDX) begin
                shadow_idx  <= '0;
                shadow_full <= 1'b1;
            end else begin
                shadow_idx <= shadow_idx + IDX_W'(1);
            end
        end
    end
`else
    assign bias_wr_ready = (state == LOAD);
    assign skip_load     = 1'b0;

    vpu_bias_bank #(.PSUM_WIDTH(PSUM_WIDTH), .NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_fire),
        .wr_idx  (lane_idx),
        .wr_data (bias_wr_data),
        .rd_flat (bias_value)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            num_rows    <= '0;
            row_cnt     <= '0;
            bias_en_q   <= 1'b0;
            lane_idx    <= '0;
            bias_enable <= 1'b0;
            done        <= 1'b0;
            row_err     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (row_valid && state != STREAM) row_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        num_rows  <= cfg_num_rows;
                        bias_en_q <= cfg_bias_en;
                        row_err   <= row_valid;
                        lane_idx  <= '0;
                        if (cfg_num_rows == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (cfg_bias_en && !skip_load) begin
                            state <= LOAD;
                        end else begin
                            state       <= STREAM;
                            bias_enable <= cfg_bias_en;
                        end
                    end
                end
                LOAD: begin
                    if (wr_fire) begin
                        if (lane_idx == LAST_IDX) begin
                            lane_idx    <= '0;
                            state       <= STREAM;
                            bias_enable <= bias_en_q;
                        end else begin
                            lane_idx <= lane_idx + IDX_W'(1);
                        end
                    end
                end
                STREAM: begin
                    if (row_valid) begin
                        if (row_last) begin
                            row_cnt     <= '0;
                            state       <= DONE;
                            done        <= 1'b1;
                            bias_enable <= 1'b0;
                        end else begin
                            row_cnt <= row_cnt + ROW_CNT_W'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_bias_ctrl.sv
// Scoreboarded random bench for vpu_bias_ctrl; job results are checked when done pulses.
// Also exercises VPU_BIAS_CTRL_DBUF_EN when that macro is defined.
module tb_vpu_bias_ctrl;
    import vpu_pkg::*;

    localparam int PW = PSUM_WIDTH_DEF;
    localparam int NL = NUM_LANES_DEF;
    localparam int RW = ROW_CNT_W_DEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start, cfg_bias_en;
    logic [RW-1:0] cfg_num_rows;
    logic          bias_wr_valid, bias_wr_ready;
    logic [PW-1:0] bias_wr_data;
    logic          row_valid, bias_enable, busy, done, row_err;
    logic [NL*PW-1:0] bias_value;
    logic          row_good;

    vpu_bias_ctrl #(.PSUM_WIDTH(PW), .NUM_LANES(NL), .ROW_CNT_W(RW)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_bias_en(cfg_bias_en),
        .cfg_num_rows(cfg_num_rows), .bias_wr_valid(bias_wr_valid),
        .bias_wr_ready(bias_wr_ready), .bias_wr_data(bias_wr_data), .row_valid(row_valid),
        .bias_enable(bias_enable), .bias_value(bias_value), .busy(busy), .done(done),
        .row_err(row_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [NL*PW-1:0] bias;
        logic             err;
    } job_exp_t;

    job_exp_t exp_q[$];
    logic     en_q[$];

    // Reference: two banks of lane words, active bank index, shadow fill count.
    psum_t model_bank [2][NL];
    int    act_m;
    int    shadow_cnt;

    function automatic logic [NL*PW-1:0] model_view();
        logic [NL*PW-1:0] v;
        for (int i = 0; i < NL; i++) v[i*PW +: PW] = model_bank[act_m][i];
        return v;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < 2; b++) for (int i = 0; i < NL; i++) model_bank[b][i] = '0;
        act_m = 0;
        shadow_cnt = 0;
    endtask

    task automatic check(input string name, input logic [NL*PW-1:0] got, input logic [NL*PW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic fail_event(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got unexpected/expired event, required none", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic en, input logic [RW-1:0] rows);
        cfg_start = 1'b1; cfg_bias_en = en; cfg_num_rows = rows;
        tick();
        cfg_start = 1'b0; cfg_bias_en = 1'($urandom); cfg_num_rows = RW'($urandom);
    endtask

    task automatic write_word(input logic [PW-1:0] d, output logic ok);
        bias_wr_valid = 1'b1; bias_wr_data = d; ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bias_wr_ready) ok = 1'b1;
            tick();
        end
        bias_wr_valid = 1'b0; bias_wr_data = PW'($urandom);
        if (!ok) fail_event("wr_timeout");
    endtask

    task automatic send_row(input logic good, input logic en);
        row_valid = 1'b1; row_good = good;
        if (good) en_q.push_back(en);
        tick();
        row_valid = 1'b0; row_good = 1'b0;
    endtask

    task automatic run_job(input logic en, input int rows, input psum_t d[NL], input int gap_max,
                           input logic inj_err, input logic ign_start);
        logic ok;
        logic err_exp;
        logic skip;
        err_exp = 1'b0;
        skip = en && (shadow_cnt == NL) && (rows != 0);
        start(en, RW'(rows));
        check("start_clears_err", row_err, 1'b0);
        if (rows == 0) begin
            exp_q.push_back('{model_view(), 1'b0});
`ifndef VPU_BIAS_CTRL_DBUF_EN
            bias_wr_valid = 1'b1; bias_wr_data = PW'($urandom);
`endif
            @(negedge clk);
            check("zero_done", done, 1'b1);
            check("zero_no_ready", bias_wr_ready, 1'b0);
            tick();
            bias_wr_valid = 1'b0;
            return;
        end
        if (skip) begin
            act_m = 1 - act_m;
            shadow_cnt = 0;
            check("swap_bias", bias_value, model_view());
            check("swap_ready", bias_wr_ready, 1'b1);
        end else if (en) begin
            for (int l = 0; l < NL; l++) begin
                repeat ($urandom_range(0, gap_max)) tick();
                if (inj_err && l == 1) begin
                    send_row(1'b0, 1'b0);
                    err_exp = 1'b1;
                end
                write_word(d[l], ok);
                model_bank[act_m][l] = d[l];
                check("load_lane_bias", bias_value, model_view());
            end
        end
        check("first_stream_en", bias_enable, en);
        exp_q.push_back('{model_view(), err_exp});
`ifndef VPU_BIAS_CTRL_DBUF_EN
        bias_wr_valid = 1'b1; bias_wr_data = PW'($urandom);
`endif
        for (int r = 0; r < rows; r++) begin
            if (r > 0) repeat ($urandom_range(0, 2)) tick();
            if (ign_start && r == 1) begin
                cfg_start = 1'b1; cfg_bias_en = !en; cfg_num_rows = RW'(rows + 7);
                tick();
                cfg_start = 1'b0;
            end
`ifndef VPU_BIAS_CTRL_DBUF_EN
            check("stream_no_ready", bias_wr_ready, 1'b0);
`endif
            send_row(1'b1, en);
        end
        bias_wr_valid = 1'b0;
        @(negedge clk);
        check("done_timing", done, 1'b1);
        check("done_busy", busy, 1'b1);
        tick();
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);
        check("idle_err_sticky", row_err, err_exp);
    endtask

    // Monitor: pops the job expectation on done and the per-row enable on good rows.
    always @(negedge clk) begin : mon
        job_exp_t e;
        if (!rst) begin
            if (done) begin
                if (exp_q.size() == 0) fail_event("done_unexpected");
                else begin
                    e = exp_q.pop_front();
                    check("job_bias", bias_value, e.bias);
                    check("job_row_err", row_err, e.err);
                    check("done_en_low", bias_enable, 1'b0);
                end
            end
            if (row_valid && row_good) begin
                if (en_q.size() == 0) fail_event("row_unexpected");
                else check("row_bias_en", bias_enable, en_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        fail_event("watchdog");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        psum_t d[NL];
        logic ok;
        logic [NL*PW-1:0] want;
        rst = 1'b1; cfg_start = 1'b0; cfg_bias_en = 1'b0; cfg_num_rows = '0;
        bias_wr_valid = 1'b0; bias_wr_data = '0; row_valid = 1'b0; row_good = 1'b0;
        model_clear();
        #12;
        check("rst_bias", bias_value, '0);
        check("rst_en", bias_enable, 1'b0);
        check("rst_ready", bias_wr_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", row_err, 1'b0);
        @(negedge clk); rst = 1'b0;
        tick();

        // Directed load with gaps, then three rows.
        d[0] = 5; d[1] = -2; d[2] = 32'h7FFF_FFFF; d[3] = 1;
        run_job(1'b1, 3, d, 2, 1'b0, 1'b0);
        want = {32'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'd5};
        check("job1_const_bias", bias_value, want);

        // Bypass job keeps the bank; zero-row job.
        run_job(1'b0, 2, d, 0, 1'b0, 1'b0);
        run_job(1'b1, 0, d, 0, 1'b0, 1'b0);

        // Error row during LOAD plus an ignored start during STREAM.
        for (int i = 0; i < NL; i++) d[i] = psum_t'($urandom);
        run_job(1'b1, 3, d, 1, 1'b1, 1'b1);

        // Random jobs.
        for (int j = 0; j < 20; j++) begin
            for (int i = 0; i < NL; i++) d[i] = psum_t'($urandom);
            run_job(1'($urandom), $urandom_range(0, 5), d, 2,
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset after two of four words.
        start(1'b1, 16'd4);
        write_word(PW'($urandom), ok);
        write_word(PW'($urandom), ok);
        #2 rst = 1'b1;
        #1;
        model_clear();
        check("mid_rst_bias", bias_value, '0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", bias_wr_ready, 1'b0);
        check("mid_rst_en", bias_enable, 1'b0);
        #3 rst = 1'b0;
        tick();
        for (int i = 0; i < NL; i++) d[i] = psum_t'($urandom);
        run_job(1'b1, 2, d, 1, 1'b0, 1'b0);

`ifdef VPU_BIAS_CTRL_DBUF_EN
        // Fill the shadow bank during a streaming job, then swap into it.
        fork
            run_job(1'b0, 6, d, 0, 1'b0, 1'b0);
            begin
                repeat (2) tick();
                for (int l = 0; l < NL; l++) begin
                    write_word(PW'(10 * (l + 1)), ok);
                    model_bank[1 - act_m][shadow_cnt] = psum_t'(10 * (l + 1));
                    shadow_cnt++;
                end
            end
        join
        run_job(1'b1, 2, d, 0, 1'b0, 1'b0);
        want = {32'd40, 32'd30, 32'd20, 32'd10};
        check("dbuf_const_bias", bias_value, want);
`endif

        repeat (5) tick();
        if (exp_q.size() != 0) fail_event("jobs_not_done");
        if (en_q.size() != 0) fail_event("rows_not_seen");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
